// File: rtl/set_local_unit.sv
// set_local_unit: executes set_local / tee_local for a stack-machine core.
// A request is latched, range-checked against the current frame, then one
// operand is popped and written to the locals RAM at frame_base + index.
// tee_local additionally pushes the same value back onto the operand stack.
// Any fault parks the unit in a sticky trap state until reset.
module set_local_unit #(
  parameter int LOCALS_ADDR = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  // request side
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op,
  input  logic [31:0]            req_index,
  input  logic [LOCALS_ADDR-1:0] frame_base,
  input  logic [LOCALS_ADDR:0]   frame_count,
  // operand stack
  input  logic                   stack_empty,
  output logic                   pop_req,
  input  logic                   pop_valid,
  input  logic [63:0]            pop_data,
  input  logic [1:0]             pop_type,
  output logic                   push_req,
  input  logic                   push_ready,
  output logic [63:0]            push_data,
  output logic [1:0]             push_type,
  // locals RAM
  output logic                   mem_we,
  output logic [LOCALS_ADDR-1:0] mem_addr,
  output logic [65:0]            mem_wdata,
  // status
  output logic                   done,
  output logic [3:0]             trap
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_POP   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_PUSH  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_TRAP  = 3'd6;

  localparam logic [3:0] TRAP_NONE      = 4'd0;
  localparam logic [3:0] TRAP_UNDERFLOW = 4'd1;
  localparam logic [3:0] TRAP_RANGE     = 4'd2;

  // The index is compared over its full 32 bits, so a huge immediate whose
  // low bits happen to look in range still traps.
  function automatic logic index_out_of_range(input logic [31:0]          idx,
                                              input logic [LOCALS_ADDR:0] cnt);
    return idx >= 32'(cnt);
  endfunction

  // Slot address wraps naturally at the RAM size.
  function automatic logic [LOCALS_ADDR-1:0] local_slot(
      input logic [LOCALS_ADDR-1:0] base,
      input logic [LOCALS_ADDR-1:0] idx_lo);
    return base + idx_lo;
  endfunction

  // control state
  logic [2:0]             state_q,     state_d;
  logic [3:0]             trap_q,      trap_d;
  logic                   pop_req_q,   pop_req_d;
  logic                   mem_we_q,    mem_we_d;
  logic                   push_req_q,  push_req_d;
  logic                   done_q,      done_d;
  logic [LOCALS_ADDR-1:0] mem_addr_q,  mem_addr_d;
  logic [65:0]            mem_wdata_q, mem_wdata_d;
  logic [63:0]            push_data_q, push_data_d;
  logic [1:0]             push_type_q, push_type_d;

  // latched request (data only, never needs clearing)
  logic                   op_q;
  logic [31:0]            index_q;
  logic [LOCALS_ADDR-1:0] base_q;
  logic [LOCALS_ADDR:0]   count_q;
  logic                   latch_en;

  // Next-state and next-output logic; every strobe defaults low so that it
  // is only ever high in the one state that owns it.
  always_comb begin
    state_d     = state_q;
    trap_d      = trap_q;
    pop_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    push_req_d  = 1'b0;
    done_d      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    push_data_d = push_data_q;
    push_type_d = push_type_q;
    latch_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          latch_en = 1'b1;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (index_out_of_range(index_q, count_q)) begin
          trap_d  = TRAP_RANGE;
          state_d = S_TRAP;
        end else if (stack_empty) begin
          trap_d  = TRAP_UNDERFLOW;
          state_d = S_TRAP;
        end else begin
          pop_req_d = 1'b1;
          state_d   = S_POP;
        end
      end
      S_POP: begin
        if (pop_valid) begin
          // the popped word lands straight in the write-data register and
          // is reused from there for the tee_local push
          mem_we_d    = 1'b1;
          mem_addr_d  = local_slot(base_q, index_q[LOCALS_ADDR-1:0]);
          mem_wdata_d = {pop_type, pop_data};
          state_d     = S_WRITE;
        end else begin
          pop_req_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (op_q) begin
          push_req_d  = 1'b1;
          push_data_d = mem_wdata_q[63:0];
          push_type_d = mem_wdata_q[65:64];
          state_d     = S_PUSH;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_PUSH: begin
        if (push_ready) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          push_req_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset abandons any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      trap_q      <= TRAP_NONE;
      pop_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      push_req_q  <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      push_data_q <= '0;
      push_type_q <= '0;
    end else begin
      state_q     <= state_d;
      trap_q      <= trap_d;
      pop_req_q   <= pop_req_d;
      mem_we_q    <= mem_we_d;
      push_req_q  <= push_req_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      push_data_q <= push_data_d;
      push_type_q <= push_type_d;
    end
  end

  // Request fields are captured on acceptance and held for the operation.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      op_q    <= req_op;
      index_q <= req_index;
      base_q  <= frame_base;
      count_q <= frame_count;
    end
  end

  // Ready follows the idle state but is forced low while reset is held.
  assign req_ready = (state_q == S_IDLE) && !reset;

  assign pop_req   = pop_req_q;
  assign mem_we    = mem_we_q;
  assign push_req  = push_req_q;
  assign done      = done_q;
  assign trap      = trap_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign push_data = push_data_q;
  assign push_type = push_type_q;

endmodule

// File: tb/tb_set_local_unit.sv
// Testbench for set_local_unit: a schedule model derives the expected output
// of every cycle of a transaction from its parameters and stall counts; one
// compare process checks the DUT each cycle, and directed transactions pin
// the model with hand-computed literals.
module tb_set_local_unit;
  localparam int A = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_op = 1'b0;
  logic [31:0]  req_index = '0;
  logic [A-1:0] frame_base = '0;
  logic [A:0]   frame_count = '0;
  logic         stack_empty = 1'b0;
  logic         pop_req;
  logic         pop_valid = 1'b0;
  logic [63:0]  pop_data = '0;
  logic [1:0]   pop_type = '0;
  logic         push_req;
  logic         push_ready = 1'b0;
  logic [63:0]  push_data;
  logic [1:0]   push_type;
  logic         mem_we;
  logic [A-1:0] mem_addr;
  logic [65:0]  mem_wdata;
  logic         done;
  logic [3:0]   trap;

  always #5 clk = ~clk;

  set_local_unit #(.LOCALS_ADDR(A)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .frame_base(frame_base), .frame_count(frame_count),
    .stack_empty(stack_empty),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data), .pop_type(pop_type),
    .push_req(push_req), .push_ready(push_ready), .push_data(push_data), .push_type(push_type),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .trap(trap)
  );

  typedef struct packed {
    logic         rdy;
    logic         pop;
    logic         we;
    logic         push;
    logic         dn;
    logic [3:0]   trp;
    logic [A-1:0] addr;
    logic [65:0]  wdata;
    logic [63:0]  pdata;
    logic [1:0]   ptype;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_cur  = '0;
  bit   exp_vld  = 1'b0;
  int   cur_t    = 0;

  // current transaction
  logic         tx_op;
  logic [31:0]  tx_idx;
  logic [A-1:0] tx_base;
  logic [A:0]   tx_cnt;
  logic         tx_empty;
  logic [63:0]  tx_val;
  logic [1:0]   tx_typ;
  int           tx_P, tx_Q;
  logic [3:0]   tx_trap;

  // observations from the DUT during the current transaction
  int           obs_we_t, obs_done_t, obs_trap_t, obs_pop_n, obs_push_n, obs_we_n;
  logic [A-1:0] obs_addr;
  logic [65:0]  obs_wdata;
  logic [63:0]  obs_pdata;
  logic [1:0]   obs_ptype;
  logic [3:0]   obs_trap;

  // Expected outputs in cycle t of the current transaction (t=0: accept cycle).
  function automatic exp_t exp_at(int t);
    exp_t e;
    int   td;
    int   slot;
    e    = '0;
    td   = tx_op ? 5 + tx_P + tx_Q : 4 + tx_P;
    slot = (int'(tx_base) + int'(tx_idx % 32'd64)) % 64;
    if (t == 0) e.rdy = 1'b1;
    else if (t == 1) e.rdy = 1'b0;
    else if (tx_trap != 4'd0) e.trp = tx_trap;
    else if (t <= 2 + tx_P) e.pop = 1'b1;
    else if (t == 3 + tx_P) begin
      e.we    = 1'b1;
      e.addr  = A'(slot);
      e.wdata = {tx_typ, tx_val};
    end else if (tx_op && t <= 4 + tx_P + tx_Q) begin
      e.push  = 1'b1;
      e.pdata = tx_val;
      e.ptype = tx_typ;
    end else if (t == td) e.dn = 1'b1;
    else e.rdy = 1'b1;
    return e;
  endfunction

  // Per-cycle compare of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    if (exp_vld) begin
      n_checks++;
      if ({req_ready, pop_req, mem_we, push_req, done, trap} !==
          {exp_cur.rdy, exp_cur.pop, exp_cur.we, exp_cur.push, exp_cur.dn, exp_cur.trp}) begin
        n_fail++;
        $display("FAIL ctrl t=%0d: got rdy=%b pop=%b we=%b push=%b done=%b trap=%0d, expected rdy=%b pop=%b we=%b push=%b done=%b trap=%0d",
                 cur_t, req_ready, pop_req, mem_we, push_req, done, trap,
                 exp_cur.rdy, exp_cur.pop, exp_cur.we, exp_cur.push, exp_cur.dn, exp_cur.trp);
      end
      if (exp_cur.we) begin
        n_checks++;
        if ({mem_addr, mem_wdata} !== {exp_cur.addr, exp_cur.wdata}) begin
          n_fail++;
          $display("FAIL wr_data t=%0d: got addr=%0d wdata=%h, expected addr=%0d wdata=%h",
                   cur_t, mem_addr, mem_wdata, exp_cur.addr, exp_cur.wdata);
        end
      end
      if (exp_cur.push) begin
        n_checks++;
        if ({push_type, push_data} !== {exp_cur.ptype, exp_cur.pdata}) begin
          n_fail++;
          $display("FAIL push_data t=%0d: got type=%0d data=%h, expected type=%0d data=%h",
                   cur_t, push_type, push_data, exp_cur.ptype, exp_cur.pdata);
        end
      end
      if (mem_we === 1'b1) begin
        obs_we_n++; obs_we_t = cur_t; obs_addr = mem_addr; obs_wdata = mem_wdata;
      end
      if (pop_req === 1'b1) obs_pop_n++;
      if (push_req === 1'b1) begin
        obs_push_n++; obs_pdata = push_data; obs_ptype = push_type;
      end
      if (done === 1'b1) obs_done_t = cur_t;
      if (trap != 4'd0 && obs_trap == 4'd0) begin
        obs_trap = trap; obs_trap_t = cur_t;
      end
    end
  end

  task automatic check_lit(input string name, input logic [65:0] act, input logic [65:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({req_ready, pop_req, push_req, mem_we, done, trap, mem_addr, mem_wdata, push_data, push_type} !== '0) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b pop=%b push=%b we=%b done=%b trap=%0d addr=%0d wdata=%h pdata=%h ptype=%0d, expected all zero",
               name, req_ready, pop_req, push_req, mem_we, done, trap, mem_addr, mem_wdata, push_data, push_type);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    exp_vld   = 1'b0;
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check_reset_outputs("reset_immediate");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    reset   = 1'b0;
    exp_cur = '0;
    exp_cur.rdy = 1'b1;
    cur_t   = 0;
    exp_vld = 1'b1;
  endtask

  task automatic run_txn(input logic op, input logic [31:0] idx, input logic [A-1:0] base,
                         input logic [A:0] cnt, input logic empty, input logic [63:0] val,
                         input logic [1:0] typ, input int P, input int Q, input int abort_t);
    int last;
    tx_op = op; tx_idx = idx; tx_base = base; tx_cnt = cnt; tx_empty = empty;
    tx_val = val; tx_typ = typ; tx_P = P; tx_Q = Q;
    tx_trap = (idx >= 32'(cnt)) ? 4'd2 : (empty ? 4'd1 : 4'd0);
    last = (tx_trap != 4'd0) ? 6 : (op ? 5 + P + Q : 4 + P);
    if (abort_t >= 0) last = abort_t;
    obs_we_t = -1; obs_done_t = -1; obs_trap_t = -1;
    obs_pop_n = 0; obs_push_n = 0; obs_we_n = 0;
    obs_addr = '0; obs_wdata = '0; obs_pdata = '0; obs_ptype = '0; obs_trap = '0;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      req_valid   = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      req_op      = (t == 0) ? op   : 1'($urandom_range(0, 1));
      req_index   = (t == 0) ? idx  : $urandom;
      frame_base  = (t == 0) ? base : A'($urandom);
      frame_count = (t == 0) ? cnt  : (A+1)'($urandom);
      stack_empty = (t == 1) ? empty : 1'($urandom_range(0, 1));
      if (tx_trap == 4'd0 && t >= 2 && t < 2 + P) pop_valid = 1'b0;
      else if (tx_trap == 4'd0 && t == 2 + P)     pop_valid = 1'b1;
      else                                        pop_valid = 1'($urandom_range(0, 1));
      pop_data = (t == 2 + P) ? val : {$urandom, $urandom};
      pop_type = (t == 2 + P) ? typ : 2'($urandom);
      if (op && tx_trap == 4'd0 && t >= 4 + P && t < 4 + P + Q) push_ready = 1'b0;
      else if (op && tx_trap == 4'd0 && t == 4 + P + Q)         push_ready = 1'b1;
      else                                                      push_ready = 1'($urandom_range(0, 1));
      exp_cur = exp_at(t + 1);
      cur_t   = t + 1;
      exp_vld = 1'b1;
    end
    if (tx_trap != 4'd0 || abort_t >= 0) do_reset();
  endtask

  initial begin
    do_reset();

    // set_local, base 10 + idx 2, i64 value 4
    run_txn(1'b0, 32'd2, 6'd10, 7'd4, 1'b0, 64'h4, 2'd1, 0, 0, -1);
    check_lit("s1_we_cycle", 66'(obs_we_t), 66'd3);
    check_lit("s1_addr", 66'(obs_addr), 66'd12);
    check_lit("s1_wdata", obs_wdata, {2'd1, 64'h4});
    check_lit("s1_done_cycle", 66'(obs_done_t), 66'd4);
    check_lit("s1_push_count", 66'(obs_push_n), 66'd0);

    // tee_local with push_ready low for three cycles
    run_txn(1'b1, 32'd0, 6'd5, 7'd3, 1'b0, 64'hFFFF_FFFF, 2'd0, 0, 3, -1);
    check_lit("s2_addr", 66'(obs_addr), 66'd5);
    check_lit("s2_push_cycles", 66'(obs_push_n), 66'd4);
    check_lit("s2_push_data", {obs_ptype, obs_pdata}, {2'd0, 64'hFFFF_FFFF});
    check_lit("s2_done_cycle", 66'(obs_done_t), 66'd8);

    // index equal to count: range trap
    run_txn(1'b0, 32'd4, 6'd0, 7'd4, 1'b0, 64'h1234, 2'd2, 0, 0, -1);
    check_lit("s3_trap_code", 66'(obs_trap), 66'd2);
    check_lit("s3_trap_cycle", 66'(obs_trap_t), 66'd2);
    check_lit("s3_no_pop", 66'(obs_pop_n), 66'd0);
    check_lit("s3_no_we", 66'(obs_we_n), 66'd0);

    // underflow, then range check taking priority over underflow
    run_txn(1'b0, 32'd0, 6'd0, 7'd1, 1'b1, 64'h0, 2'd0, 0, 0, -1);
    check_lit("s4_underflow", 66'(obs_trap), 66'd1);
    check_lit("s4_no_pop", 66'(obs_pop_n), 66'd0);
    run_txn(1'b0, 32'd7, 6'd0, 7'd2, 1'b1, 64'h0, 2'd0, 0, 0, -1);
    check_lit("s4_priority", 66'(obs_trap), 66'd2);

    // huge index whose low bits look in range
    run_txn(1'b0, 32'h0000_0100, 6'd0, 7'd64, 1'b0, 64'h0, 2'd0, 0, 0, -1);
    check_lit("s5_wide_index", 66'(obs_trap), 66'd2);

    // address wrap and delayed pop
    run_txn(1'b0, 32'd3, 6'd62, 7'd8, 1'b0, 64'hDEAD_BEEF_0000_0001, 2'd3, 2, 0, -1);
    check_lit("s6_addr_wrap", 66'(obs_addr), 66'd1);
    check_lit("s6_we_cycle", 66'(obs_we_t), 66'd5);

    // reset during a pop stall, then a clean request
    run_txn(1'b0, 32'd1, 6'd0, 7'd4, 1'b0, 64'h55, 2'd1, 3, 0, 3);
    check_lit("s7_no_we", 66'(obs_we_n), 66'd0);
    run_txn(1'b1, 32'd1, 6'd20, 7'd4, 1'b0, 64'h77, 2'd2, 0, 0, -1);
    check_lit("s7_after_done", 66'(obs_done_t), 66'd5);
    check_lit("s7_after_addr", 66'(obs_addr), 66'd21);

    // randomized transactions
    for (int n = 0; n < 200; n++) begin
      logic        op, empty;
      logic [A:0]  cnt;
      logic [31:0] idx;
      int          P, Q, sel, ab, td;
      op    = 1'($urandom_range(0, 1));
      cnt   = (A+1)'($urandom_range(1, 64));
      sel   = $urandom_range(0, 9);
      if (sel < 8)       idx = $urandom_range(0, int'(cnt) - 1);
      else if (sel == 8) idx = 32'(cnt) + $urandom_range(0, 5);
      else               idx = $urandom;
      empty = ($urandom_range(0, 9) == 0);
      P     = $urandom_range(0, 3);
      Q     = $urandom_range(0, 3);
      td    = op ? 5 + P + Q : 4 + P;
      ab    = ($urandom_range(0, 19) == 0) ? $urandom_range(1, td - 1) : -1;
      run_txn(op, idx, A'($urandom), cnt, empty, {$urandom, $urandom}, 2'($urandom), P, Q, ab);
    end

    @(negedge clk);
    exp_vld = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/set_local_unit.md
SET_LOCAL_UNIT -- requirements
Module: set_local_unit

Interface
REQ-001 Parameter: LOCALS_ADDR, default 6, address width of the locals RAM (64 slots).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  a set_local/tee_local request is offered.
REQ-005 req_ready  output  1  unit is idle and accepts a request this cycle.
REQ-006 req_op  input  1  0 = set_local, 1 = tee_local.
REQ-007 req_index  input  32  decoded local index (immediate).
REQ-008 frame_base  input  LOCALS_ADDR  base slot of the current call frame.
REQ-009 frame_count  input  LOCALS_ADDR+1  number of locals (params + declared) in the frame.
REQ-010 stack_empty  input  1  operand stack holds no entries.
REQ-011 pop_req / pop_valid  output / input  1 / 1  operand-stack pop handshake.
REQ-012 pop_data / pop_type  input  64 / 2  popped value and type tag (i32, i64, f32, f64 encoding).
REQ-013 push_req / push_ready  output / input  1 / 1  operand-stack push handshake (tee_local only).
REQ-014 push_data / push_type  output  64 / 2  value and type pushed back.
REQ-015 mem_we  output  1  locals RAM write strobe.
REQ-016 mem_addr  output  LOCALS_ADDR  locals RAM address.
REQ-017 mem_wdata  output  66  {type[1:0], value[63:0]}.
REQ-018 done  output  1  one-cycle pulse on successful completion.
REQ-019 trap  output  4  0 none, 1 stack underflow, 2 local index out of range.

Function
REQ-020 FSM states SHALL be IDLE, CHECK, POP, WRITE, PUSH, DONE, TRAP.
REQ-021 IDLE: req_ready=1; on req_valid, latch req_op, req_index, frame_base, frame_count; go to CHECK.
REQ-022 CHECK: if req_index >= frame_count (unsigned, full 32-bit compare) go to TRAP with trap=2; else if stack_empty go to TRAP with trap=1; else go to POP; index check has priority.
REQ-023 POP: assert pop_req continuously until the cycle pop_valid=1; capture pop_data/pop_type that cycle; go to WRITE.
REQ-024 WRITE: assert mem_we for exactly one cycle with mem_addr = (frame_base + req_index[LOCALS_ADDR-1:0]) modulo 2^LOCALS_ADDR and mem_wdata = captured type and value; next PUSH if tee_local else DONE.
REQ-025 PUSH: assert push_req with captured value and type until the cycle push_ready=1; then DONE.
REQ-026 DONE: done=1 for one cycle; return to IDLE; req_ready reasserts the following cycle.
REQ-027 Minimum latency, accept edge = cycle 0: set_local mem_we in cycle 3, done in cycle 4; tee_local push_req in cycle 4, done in cycle 5 (pop_valid and push_ready high immediately).
REQ-028 Each stall cycle of pop_valid or push_ready low SHALL add exactly one cycle; outputs SHALL hold stable while stalled.
REQ-029 TRAP: trap held at its code, req_ready=0, no mem_we/pop_req/push_req, until reset.
REQ-030 req_valid outside IDLE SHALL be ignored; pop_valid/push_ready outside POP/PUSH SHALL be ignored.
REQ-031 Value and type SHALL be written unmodified (no type check against the local's declared type).
REQ-032 mem_we, pop_req, push_req, done SHALL be registered outputs, never asserted simultaneously.

Reset
REQ-033 reset=1 SHALL immediately force state IDLE, trap=0, done=0, mem_we=0, pop_req=0, push_req=0, mem_addr=0, mem_wdata=0, push_data=0, push_type=0, req_ready=0 while reset is held, req_ready=1 in the first cycle after release.
REQ-034 Reset mid-operation SHALL abandon the request with no further RAM write or stack push.

Verification
REQ-035 set_local idx 2, frame_base 10, frame_count 4, pop 0x4 type i64 -> mem_we cycle 3, mem_addr 12, mem_wdata {i64,4}, done cycle 4, no push.
REQ-036 tee_local idx 0, base 5, pop 0xFFFFFFFF i32, push_ready low 3 cycles -> write addr 5, push_data 0xFFFFFFFF i32 held 4 cycles, done cycle 8.
REQ-037 set_local idx 4, frame_count 4 -> trap=2 in cycle 2, no pop_req, no mem_we; req_ready stays 0 until reset.
REQ-038 set_local idx 0, frame_count 1, stack_empty=1 -> trap=1, no pop_req; idx 7, count 2, stack_empty=1 -> trap=2 (priority).
REQ-039 base 62, idx 3, LOCALS_ADDR 6 -> mem_addr 1 (wrap); pop_valid delayed 2 cycles -> mem_we cycle 5.
REQ-040 reset asserted during POP stall -> all outputs zero immediately, no mem_we after release, next request completes normally.
